// File: rtl/conn_table_pkg.sv
// Shared definitions for the connection table: key geometry, tuple field
// offsets, the lookup FSM state type and the table-full response code.
package conn_table_pkg;

    localparam int TUPLE_W      = 128;
    localparam int KEY_W        = 104;

    localparam int PROTO_LSB    = 0;
    localparam int DST_PORT_LSB = 8;
    localparam int SRC_PORT_LSB = 24;
    localparam int DST_IP_LSB   = 40;
    localparam int SRC_IP_LSB   = 72;

    localparam logic [15:0] FULL_CODE = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        PROBE,
        RESP,
        WAIT_DROP
    } state_e;

endpackage

// File: rtl/conn_table_if.sv
// Lookup request/response bundle between a requester (master) and the
// connection table (slave).
interface conn_table_if;
    import conn_table_pkg::*;

    logic [TUPLE_W-1:0] tuple_data_i;
    logic               tuple_valid_i;
    logic [15:0]        conn_data_o;
    logic               conn_valid_o;

    modport master (
        output tuple_data_i,
        output tuple_valid_i,
        input  conn_data_o,
        input  conn_valid_o
    );

    modport slave (
        input  tuple_data_i,
        input  tuple_valid_i,
        output conn_data_o,
        output conn_valid_o
    );

endinterface

// File: rtl/conn_table_hash.sv
// XOR-fold of the 104-bit key into a HASH_LEN-bit table index; key bit i
// lands on index bit i mod HASH_LEN, which equals chunk-wise XOR with a
// zero-padded top chunk.
module conn_hash
    import conn_table_pkg::*;
#(
    parameter int HASH_LEN = 6
) (
    input  logic [KEY_W-1:0]    key_i,
    output logic [HASH_LEN-1:0] index_o
);

    always_comb begin
        index_o = '0;
        for (int i = 0; i < KEY_W; i++) begin
            index_o[i % HASH_LEN] = index_o[i % HASH_LEN] ^ key_i[i];
        end
    end

endmodule

// File: rtl/conn_table.sv
// Hashed connection table with linear probing: a new 5-tuple key is assigned
// the first free slot from its hash, and the slot maps to a translated port.
module conn_table
    import conn_table_pkg::*;
#(
    parameter int          HASH_LEN  = 6,
    parameter logic [15:0] PORT_BASE = 16'hC000
) (
    input  logic              clk,
    input  logic              reset,
    conn_table_if.slave       bus,
    input  logic              flush_i,
    output logic              table_full_o,
    output logic [HASH_LEN:0] occupancy_o
);

    localparam int ENTRIES = 1 << HASH_LEN;
    localparam logic [HASH_LEN:0] ENTRIES_CNT = {1'b1, {HASH_LEN{1'b0}}};

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [HASH_LEN-1:0] slot_q, slot_d;
    logic [HASH_LEN-1:0] probe_q, probe_d;
    logic [HASH_LEN:0]   occ_q, occ_d;
    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [15:0]         conn_data_q, conn_data_d;
    logic [KEY_W-1:0]    keys_q [ENTRIES];
    logic                key_wr;
    logic [HASH_LEN-1:0] hash_idx;
    logic                unused_tuple_bits;

    assign unused_tuple_bits = ^bus.tuple_data_i[TUPLE_W-1:KEY_W];

    conn_hash #(
        .HASH_LEN (HASH_LEN)
    ) u_hash (
        .key_i   (key_q),
        .index_o (hash_idx)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        slot_d      = slot_q;
        probe_d     = probe_q;
        occ_d       = occ_q;
        valid_d     = valid_q;
        conn_data_d = conn_data_q;
        key_wr      = 1'b0;

        case (state_q)
            IDLE: begin
                // Flush takes priority; a concurrent request waits one cycle.
                if (flush_i) begin
                    valid_d = '0;
                    occ_d   = '0;
                end else if (bus.tuple_valid_i) begin
                    key_d   = bus.tuple_data_i[KEY_W-1:0];
                    state_d = HASH;
                end
            end
            HASH: begin
                slot_d  = hash_idx;
                probe_d = '0;
                state_d = PROBE;
            end
            PROBE: begin
                if (valid_q[slot_q] && (keys_q[slot_q] == key_q)) begin
                    conn_data_d = PORT_BASE + 16'(slot_q);
                    state_d     = RESP;
                end else if (!valid_q[slot_q]) begin
                    key_wr          = 1'b1;
                    valid_d[slot_q] = 1'b1;
                    occ_d           = occ_q + 1'b1;
                    conn_data_d     = PORT_BASE + 16'(slot_q);
                    state_d         = RESP;
                end else if (probe_q == '1) begin
                    conn_data_d = FULL_CODE;
                    state_d     = RESP;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    probe_d = probe_q + 1'b1;
                end
            end
            RESP: begin
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                // A still-held request must not be served a second time.
                if (!bus.tuple_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            probe_q     <= '0;
            occ_q       <= '0;
            valid_q     <= '0;
            conn_data_q <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            probe_q     <= probe_d;
            occ_q       <= occ_d;
            valid_q     <= valid_d;
            conn_data_q <= conn_data_d;
        end
    end

    // Key storage is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        if (key_wr) begin
            keys_q[slot_q] <= key_q;
        end
    end

    assign bus.conn_valid_o = (state_q == RESP);
    assign bus.conn_data_o  = conn_data_q;
    assign occupancy_o      = occ_q;
    assign table_full_o     = (occ_q == ENTRIES_CNT);

endmodule

// File: tb/tb_conn_table.sv
// Directed self-checking bench for conn_table with the default 64-entry
// geometry; expected ports and latencies are worked out by hand from hashes.
module tb_conn_table;
    import conn_table_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush_i = 1'b0;
    logic       table_full_o;
    logic [6:0] occupancy_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] tuple_a;
    logic [127:0] tuple_b;

    conn_table_if bus ();

    conn_table #(
        .HASH_LEN  (6),
        .PORT_BASE (16'hC000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flush_i      (flush_i),
        .table_full_o (table_full_o),
        .occupancy_o  (occupancy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mk_tuple(input logic [31:0] sip, input logic [31:0] dip,
                                              input logic [15:0] sp, input logic [15:0] dp,
                                              input logic [7:0] proto);
        logic [127:0] t;
        t = '0;
        t[SRC_IP_LSB +: 32]   = sip;
        t[DST_IP_LSB +: 32]   = dip;
        t[SRC_PORT_LSB +: 16] = sp;
        t[DST_PORT_LSB +: 16] = dp;
        t[PROTO_LSB +: 8]     = proto;
        return t;
    endfunction

    // mode: 0 plain, 1 drop request right after capture, 2 flush in the
    // request's first cycle, 3 flush held while the lookup is in flight.
    task automatic run_lookup(input logic [127:0] tuple, input int hold_after, input int mode,
                              output logic [15:0] data, output int lat, output int pulses);
        int cap_edge;
        cap_edge = (mode == 2) ? 2 : 1;
        data   = 16'hxxxx;
        pulses = 0;
        lat    = 0;
        @(negedge clk);
        bus.tuple_data_i  = tuple;
        bus.tuple_valid_i = 1'b1;
        if (mode == 2) flush_i = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) flush_i = (mode == 3);
            if (lat == cap_edge) bus.tuple_data_i = '1;
            if (mode == 1 && lat == 1) bus.tuple_valid_i = 1'b0;
            if (bus.conn_valid_o) break;
        end
        if (bus.conn_valid_o) begin
            pulses = 1;
            data   = bus.conn_data_o;
        end else begin
            lat = -1;
        end
        flush_i = 1'b0;
        repeat (hold_after) begin
            @(posedge clk);
            #1;
            if (bus.conn_valid_o) pulses++;
        end
        bus.tuple_valid_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.conn_valid_o) pulses++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.conn_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.conn_valid_o); end
        checks++;
        if (bus.conn_data_o !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", bus.conn_data_o); end
        checks++;
        if (occupancy_o !== 7'd0) begin errors++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy_o); end
        checks++;
        if (table_full_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", table_full_o); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_miss_insert();
        logic [15:0] d; int lat; int p;
        run_lookup(tuple_a, 0, 0, d, lat, p);
        checks++;
        if (d !== 16'hC006) begin errors++; $display("[TB] FAIL insert_a_data: got %h expected c006", d); end
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL insert_a_latency: got %0d expected 3", lat); end
        checks++;
        if (occupancy_o !== 7'd1) begin errors++; $display("[TB] FAIL insert_a_occ: got %0d expected 1", occupancy_o); end
    endtask

    task automatic test_hit();
        logic [15:0] d; int lat; int p;
        run_lookup(tuple_a, 0, 0, d, lat, p);
        checks++;
        if (d !== 16'hC006) begin errors++; $display("[TB] FAIL hit_a_data: got %h expected c006", d); end
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL hit_a_latency: got %0d expected 3", lat); end
        checks++;
        if (occupancy_o !== 7'd1) begin errors++; $display("[TB] FAIL hit_a_occ: got %0d expected 1", occupancy_o); end
    endtask

    task automatic test_collision();
        logic [15:0] d; int lat; int p;
        run_lookup(tuple_b, 0, 0, d, lat, p);
        checks++;
        if (d !== 16'hC007) begin errors++; $display("[TB] FAIL collide_b_data: got %h expected c007", d); end
        checks++;
        if (lat !== 4) begin errors++; $display("[TB] FAIL collide_b_latency: got %0d expected 4", lat); end
        checks++;
        if (occupancy_o !== 7'd2) begin errors++; $display("[TB] FAIL collide_b_occ: got %0d expected 2", occupancy_o); end
    endtask

    task automatic test_hold_and_flush();
        logic [15:0] d; int lat; int p;
        run_lookup(tuple_a, 5, 0, d, lat, p);
        checks++;
        if (p !== 1) begin errors++; $display("[TB] FAIL hold_pulses: got %0d expected 1", p); end
        checks++;
        if (d !== 16'hC006) begin errors++; $display("[TB] FAIL hold_data: got %h expected c006", d); end
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (occupancy_o !== 7'd0) begin errors++; $display("[TB] FAIL flush_occ: got %0d expected 0", occupancy_o); end
        run_lookup(tuple_a, 0, 0, d, lat, p);
        checks++;
        if (d !== 16'hC006) begin errors++; $display("[TB] FAIL reinsert_a_data: got %h expected c006", d); end
        checks++;
        if (occupancy_o !== 7'd1) begin errors++; $display("[TB] FAIL reinsert_a_occ: got %0d expected 1", occupancy_o); end
    endtask

    task automatic test_drop_early();
        logic [15:0] d; int lat; int p;
        run_lookup(tuple_a, 0, 1, d, lat, p);
        checks++;
        if (p !== 1) begin errors++; $display("[TB] FAIL drop_early_pulses: got %0d expected 1", p); end
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL drop_early_latency: got %0d expected 3", lat); end
    endtask

    task automatic test_flush_ignored();
        logic [15:0] d; int lat; int p;
        run_lookup(tuple_b, 0, 3, d, lat, p);
        checks++;
        if (d !== 16'hC007) begin errors++; $display("[TB] FAIL busy_flush_data: got %h expected c007", d); end
        checks++;
        if (occupancy_o !== 7'd2) begin errors++; $display("[TB] FAIL busy_flush_occ: got %0d expected 2", occupancy_o); end
    endtask

    task automatic test_flush_priority();
        logic [15:0] d; int lat; int p;
        run_lookup(tuple_a, 0, 2, d, lat, p);
        checks++;
        if (lat !== 4) begin errors++; $display("[TB] FAIL flush_prio_latency: got %0d expected 4", lat); end
        checks++;
        if (d !== 16'hC006) begin errors++; $display("[TB] FAIL flush_prio_data: got %h expected c006", d); end
        checks++;
        if (occupancy_o !== 7'd1) begin errors++; $display("[TB] FAIL flush_prio_occ: got %0d expected 1", occupancy_o); end
    endtask

    task automatic test_full();
        logic [15:0] d; int lat; int p;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            run_lookup(mk_tuple(32'h0, 32'h0, 16'h0, 16'h0, 8'(i)), 0, 0, d, lat, p);
            checks++;
            if (d !== 16'hC000 + 16'(i) || lat !== 3) begin
                errors++;
                $display("[TB] FAIL fill_%0d: got %h lat %0d expected %h lat 3", i, d, lat, 16'hC000 + 16'(i));
            end
        end
        checks++;
        if (occupancy_o !== 7'd64) begin errors++; $display("[TB] FAIL full_occ: got %0d expected 64", occupancy_o); end
        checks++;
        if (table_full_o !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %b expected 1", table_full_o); end
        run_lookup(tuple_b, 0, 0, d, lat, p);
        checks++;
        if (d !== 16'hFFFF) begin errors++; $display("[TB] FAIL full_miss_data: got %h expected ffff", d); end
        checks++;
        if (lat !== 66) begin errors++; $display("[TB] FAIL full_miss_latency: got %0d expected 66", lat); end
        run_lookup(mk_tuple(32'h0, 32'h0, 16'h0, 16'h0, 8'h20), 0, 0, d, lat, p);
        checks++;
        if (d !== 16'hC020 || lat !== 3) begin errors++; $display("[TB] FAIL full_hit: got %h lat %0d expected c020 lat 3", d, lat); end
        checks++;
        if (occupancy_o !== 7'd64) begin errors++; $display("[TB] FAIL full_hit_occ: got %0d expected 64", occupancy_o); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] d; int lat; int p;
        int stray;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        run_lookup(tuple_a, 0, 0, d, lat, p);
        @(negedge clk);
        bus.tuple_data_i  = tuple_b;
        bus.tuple_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.conn_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b expected 0", bus.conn_valid_o); end
        checks++;
        if (occupancy_o !== 7'd0) begin errors++; $display("[TB] FAIL abort_occ: got %0d expected 0", occupancy_o); end
        bus.tuple_valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.conn_valid_o) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("[TB] FAIL abort_no_resp: got %0d pulses expected 0", stray); end
        run_lookup(tuple_a, 0, 0, d, lat, p);
        checks++;
        if (d !== 16'hC006 || lat !== 3) begin errors++; $display("[TB] FAIL abort_reinsert: got %h lat %0d expected c006 lat 3", d, lat); end
        checks++;
        if (occupancy_o !== 7'd1) begin errors++; $display("[TB] FAIL abort_reinsert_occ: got %0d expected 1", occupancy_o); end
    endtask

    initial begin
        bus.tuple_data_i  = '0;
        bus.tuple_valid_i = 1'b0;
        tuple_a = mk_tuple(32'h0, 32'h0, 16'h0, 16'h0, 8'h06);
        tuple_b = mk_tuple(32'h0, 32'h0, 16'h0, 16'h0060, 8'h00);
        test_reset();
        test_miss_insert();
        test_hit();
        test_collision();
        test_hold_and_flush();
        test_drop_early();
        test_flush_ignored();
        test_flush_priority();
        test_full();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conn_table.md
CONN_TABLE -- requirements
Module: conn_table

Interface
REQ-001 The block SHALL have parameter HASH_LEN, default 6, meaning table index width, giving 2^HASH_LEN entries; legal range 1..12.
REQ-002 The block SHALL have parameter PORT_BASE, default 16'hC000, meaning the translated port returned for slot 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tuple_data_i, input, 128 bits: {24'h0, src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], protocol[7:0]}; the key is bits [103:0].
REQ-006 The block SHALL have port tuple_valid_i, input, 1 bit: lookup request level, held by the requester until it sees conn_valid_o.
REQ-007 The block SHALL have port conn_data_o, output, 16 bits: translated port for the request.
REQ-008 The block SHALL have port conn_valid_o, output, 1 bit: one-cycle response strobe qualifying conn_data_o.
REQ-009 The block SHALL have port flush_i, input, 1 bit: clears all table entries.
REQ-010 The block SHALL have port table_full_o, output, 1 bit: occupancy equals 2^HASH_LEN.
REQ-011 The block SHALL have port occupancy_o, output, HASH_LEN+1 bits: count of valid entries.

Function
REQ-012 FSM states SHALL be IDLE, HASH, PROBE, RESP, WAIT_DROP.
REQ-013 IDLE with tuple_valid_i=1 and flush_i=0 SHALL capture key bits [103:0] into a register and go to HASH; tuple_data_i is not sampled again for that request.
REQ-014 HASH SHALL register index = XOR of key split into HASH_LEN-bit chunks from bit 0 upward, top chunk zero-padded; clear the probe counter; go to PROBE.
REQ-015 Each PROBE cycle SHALL examine one slot: valid and key equal = hit; invalid = insert key, set valid, increment occupancy; either case go to RESP with result = PORT_BASE + slot (16-bit, modulo 2^16).
REQ-016 Otherwise, slot SHALL advance by 1 modulo 2^HASH_LEN and the probe counter by 1; after 2^HASH_LEN probes without hit or free slot, result SHALL be 16'hFFFF and the FSM go to RESP.
REQ-017 In RESP, conn_valid_o SHALL be 1 for exactly one cycle with conn_data_o = result, then the FSM goes to WAIT_DROP.
REQ-018 conn_data_o SHALL hold its last value until the next response.
REQ-019 WAIT_DROP SHALL return to IDLE only when tuple_valid_i=0, so a held request is never served twice.
REQ-020 Latency SHALL be: request sampled in IDLE at cycle N, first slot probed at N+2, conn_valid_o high at N+2+k for a decision on probe k (k=1 best case, giving N+3).
REQ-021 flush_i SHALL act only in IDLE and SHALL win over a same-cycle request: it clears all valid bits and zeroes occupancy in one cycle, and the request is taken the next cycle.
REQ-022 flush_i outside IDLE SHALL be ignored.
REQ-023 tuple_valid_i dropping before the response SHALL NOT abort the lookup; the response is still issued and the FSM then returns to IDLE.
REQ-024 table_full_o SHALL equal (occupancy_o == 2^HASH_LEN) combinationally.

Reset
REQ-025 reset=0 SHALL asynchronously force: state IDLE, conn_valid_o=0, conn_data_o=0, occupancy_o=0, all valid bits 0, probe counter 0.
REQ-026 Reset SHALL abort any in-flight lookup with no response.
REQ-027 Key storage SHALL need no reset, since entries are qualified by valid bits.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the key width constant (104), the tuple field offsets and the 16'hFFFF full-table code.
REQ-029 Sub-module conn_hash SHALL hold the combinational XOR-fold, parameterised by HASH_LEN.
REQ-030 Key storage SHALL be a 2^HASH_LEN x 104 register array with a separate valid-bit vector.

Verification
REQ-031 Reset; tuple A (all zero, protocol=8'h06, hash 6) -> conn_valid_o at N+3 with conn_data_o=16'hC006; occupancy_o=1.
REQ-032 Repeat tuple A -> hit, conn_data_o=16'hC006 at N+3; occupancy_o stays 1.
REQ-033 Tuple B (protocol=8'h00, dst_port=16'h0060, hash 6) after A -> two probes, conn_data_o=16'hC007 at N+4; occupancy_o=2.
REQ-034 Insert 64 distinct tuples, then a 65th new one -> table_full_o=1, response 16'hFFFF after 64 probes; a previously inserted tuple still hits correctly.
REQ-035 Hold tuple_valid_i high 5 cycles after the response -> exactly one conn_valid_o pulse; after release, flush_i in IDLE -> occupancy_o=0, and tuple A reinserts at 16'hC006.
REQ-036 Assert reset during PROBE for tuple B -> no conn_valid_o, occupancy_o=0; a new lookup of A returns 16'hC006 as a miss-insert.
